// File: rtl/cluster_pkg.sv
// cluster_pkg: shared types, constants and the source-select function for the cluster ring.
//   CLUSTER_N   default node count
//   CLUSTER_DW  default ring word width
//   mode_t      topology select: forward, reverse, broadcast, loopback
//   flush_st_t  flush controller states
//   hop_word_t  reference layout of one pipeline stage at the default width
//   src_of      index of the node whose hop feeds destination j
package cluster_pkg;
    localparam int CLUSTER_N  = 3;
    localparam int CLUSTER_DW = 32;
    typedef enum logic [1:0] {
        MODE_FWD   = 2'd0,
        MODE_REV   = 2'd1,
        MODE_BCAST = 2'd2,
        MODE_LOOP  = 2'd3
    } mode_t;
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } flush_st_t;
    typedef struct packed {
        logic                  stb;
        logic [CLUSTER_DW-1:0] data;
        logic                  par;
    } hop_word_t;
    // Broadcast: node 0 feeds everyone else, and node 0 hears the last node.
    function automatic int src_of(mode_t m, int j, int n);
        return (m == MODE_FWD)   ? (j + 1) % n :
               (m == MODE_REV)   ? (j + n - 1) % n :
               (m == MODE_BCAST) ? ((j == 0) ? n - 1 : 0) : j;
    endfunction
endpackage

// File: rtl/cluster_ring_if.sv
// cluster_ring_if: per-node data path bundle between the cluster nodes and the ring.
//   node_out/node_out_stb  words and send strobes launched by each node
//   par_inj                per-node parity corruption hook
//   node_in/node_in_stb    received words and one-cycle receive strobes
//   link_ok                per-node link-alive flags
//   par_err                per-node sticky parity error flags
//   master: node side, slave: ring side
interface cluster_ring_if #(
    parameter int N  = 3,
    parameter int DW = 32
);
    logic [N-1:0][DW-1:0] node_out;
    logic [N-1:0]         node_out_stb;
    logic [N-1:0]         par_inj;
    logic [N-1:0][DW-1:0] node_in;
    logic [N-1:0]         node_in_stb;
    logic [N-1:0]         link_ok;
    logic [N-1:0]         par_err;
    modport master (
        output node_out, node_out_stb, par_inj,
        input  node_in, node_in_stb, link_ok, par_err
    );
    modport slave (
        input  node_out, node_out_stb, par_inj,
        output node_in, node_in_stb, link_ok, par_err
    );
endinterface

// File: rtl/cluster_hop.sv
// cluster_hop: one HOP_LAT-stage shift pipeline carrying a node's strobe and word.
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clr       flush: clears every stage strobe and blocks new launches
//   i_stb       launch strobe, i_data launch word, i_inj inverts launched parity
//   o_stb       strobe leaving the last stage, o_data its word
//   o_ok        parity of the leaving word checks out (always 1 without parity)
// Macro CLUSTER_RING_PARITY_EN adds an even-parity bit per stage.
module cluster_hop
    import cluster_pkg::*;
#(
    parameter int DW      = CLUSTER_DW,
    parameter int HOP_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_stb,
    input  logic          i_inj,
    input  logic [DW-1:0] i_data,
    output logic          o_stb,
    output logic [DW-1:0] o_data,
    output logic          o_ok
);
    logic [HOP_LAT-1:0]         r_stb;
    logic [HOP_LAT-1:0][DW-1:0] r_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb  <= '0;
            r_data <= '0;
        end else begin
            r_stb[0]  <= i_stb & ~i_clr;
            r_data[0] <= i_data;
            for (int k = 1; k < HOP_LAT; k++) begin
                r_stb[k]  <= r_stb[k-1] & ~i_clr;
                r_data[k] <= r_data[k-1];
            end
        end
    end
    assign o_stb  = r_stb[HOP_LAT-1];
    assign o_data = r_data[HOP_LAT-1];
`ifdef CLUSTER_RING_PARITY_EN
    logic [HOP_LAT-1:0] r_par;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= '0;
        end else begin
            r_par[0] <= (^i_data) ^ i_inj;
            for (int k = 1; k < HOP_LAT; k++) r_par[k] <= r_par[k-1];
        end
    end
    assign o_ok = (^r_data[HOP_LAT-1]) == r_par[HOP_LAT-1];
`else
    logic w_unused;
    assign w_unused = i_inj;
    assign o_ok     = 1'b1;
`endif
endmodule

// File: rtl/cluster_ring.sv
// cluster_ring: N-node ring interconnect with selectable topology, flush on mode change,
// per-node link watchdog and optional hop parity.
//   clk, rst_n  clock, asynchronous active-low reset
//   mode        topology select (mode_t)
//   par_clr     clears all sticky parity errors
//   flushing    high while a mode-change flush is in progress
//   bus         cluster_ring_if.slave: node words/strobes in and out, link_ok, par_err, par_inj
// Macro CLUSTER_RING_PARITY_EN enables hop parity and par_err.
module cluster_ring
    import cluster_pkg::*;
#(
    parameter int N         = CLUSTER_N,
    parameter int DW        = CLUSTER_DW,
    parameter int HOP_LAT   = 4,
    parameter int STALE_MAX = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  mode_t         mode,
    input  logic          par_clr,
    output logic          flushing,
    cluster_ring_if.slave bus
);
    localparam int          SW       = $clog2(N);
    localparam logic [15:0] WD_MAX   = 16'(STALE_MAX);
    localparam logic [3:0]  CNT_INIT = 4'(HOP_LAT - 1);
    flush_st_t            r_state, w_state_nxt;
    logic [3:0]           r_cnt, w_cnt_nxt;
    mode_t                r_mode;
    logic                 w_chg;
    logic [N-1:0]         w_hop_stb, w_hop_ok, w_rx_stb;
    logic [N-1:0][DW-1:0] w_hop_data, w_rx_data, r_hold;
    logic [N-1:0][SW-1:0] w_src;
    logic [N-1:0][15:0]   r_wd;
    // The registered mode tracks the input every cycle, so any difference is a fresh change
    // and also restarts the count when it lands mid-flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_mode  <= mode;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= mode;
        end
    end
    always_comb begin
        w_chg       = mode != r_mode;
        w_state_nxt = (w_chg || (r_state == ST_FLUSH && r_cnt != '0)) ? ST_FLUSH : ST_RUN;
        w_cnt_nxt   = w_chg ? CNT_INIT : (r_cnt != '0) ? r_cnt - 4'd1 : r_cnt;
    end
    always_comb flushing = r_state == ST_FLUSH;
    // Hop g carries node g's launches; destinations pick a hop output by topology.
    for (genvar g = 0; g < N; g++) begin : g_hop
        cluster_hop #(.DW(DW), .HOP_LAT(HOP_LAT)) u_hop (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_clr  (flushing),
            .i_stb  (bus.node_out_stb[g]),
            .i_inj  (bus.par_inj[g]),
            .i_data (bus.node_out[g]),
            .o_stb  (w_hop_stb[g]),
            .o_data (w_hop_data[g]),
            .o_ok   (w_hop_ok[g])
        );
    end
    always_comb begin
        w_src     = '0;
        w_rx_stb  = '0;
        w_rx_data = '0;
        for (int j = 0; j < N; j++) begin
            w_src[j]     = SW'(src_of(r_mode, j, N));
            w_rx_stb[j]  = w_hop_stb[w_src[j]] & w_hop_ok[w_src[j]] & ~flushing;
            w_rx_data[j] = w_hop_data[w_src[j]];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
            r_wd   <= {N{WD_MAX}};
        end else begin
            for (int j = 0; j < N; j++) begin
                if (w_rx_stb[j]) r_hold[j] <= w_rx_data[j];
                r_wd[j] <= w_rx_stb[j] ? '0 : (r_wd[j] == WD_MAX) ? r_wd[j] : r_wd[j] + 16'd1;
            end
        end
    end
    // node_in shows the arriving word in its strobe cycle, then holds it.
    always_comb begin
        bus.node_in = '0;
        bus.link_ok = '0;
        for (int j = 0; j < N; j++) begin
            bus.node_in[j] = w_rx_stb[j] ? w_rx_data[j] : r_hold[j];
            bus.link_ok[j] = r_wd[j] < WD_MAX;
        end
    end
    assign bus.node_in_stb = w_rx_stb;
`ifdef CLUSTER_RING_PARITY_EN
    logic [N-1:0] r_par_err;
    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= '0;
        end else begin
            for (int j = 0; j < N; j++)
                r_par_err[j] <= (w_hop_stb[w_src[j]] & ~w_hop_ok[w_src[j]] & ~flushing) |
                                (r_par_err[j] & ~par_clr);
        end
    end
    assign bus.par_err = r_par_err;
`else
    logic w_unused;
    assign w_unused    = par_clr;
    assign bus.par_err = '0;
`endif
endmodule

// File: tb/tb_cluster_ring.sv
// tb_cluster_ring: directed self-checking bench for cluster_ring (N=3, DW=32, HOP_LAT=4, STALE_MAX=255).
// Parity scenarios follow CLUSTER_RING_PARITY_EN.
module tb_cluster_ring;
    import cluster_pkg::*;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int HL = 4;
    localparam int SM = 255;
    logic  clk     = 1'b0;
    logic  rst_n   = 1'b0;
    logic  par_clr = 1'b0;
    logic  flushing;
    mode_t mode    = MODE_FWD;
    int    checks   = 0;
    int    failures = 0;
    cluster_ring_if #(.N(N), .DW(DW)) bus ();
    cluster_ring #(.N(N), .DW(DW), .HOP_LAT(HL), .STALE_MAX(SM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .par_clr  (par_clr),
        .flushing (flushing),
        .bus      (bus)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_inputs();
        bus.node_out     = '0;
        bus.node_out_stb = '0;
        bus.par_inj      = '0;
    endtask
    task automatic change_mode(input mode_t m);
        mode = m;
        repeat (HL + 1) tick();
    endtask
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.node_in !== '0) begin failures++; $display("FAIL reset_node_in got=%h exp=0", bus.node_in); end
        checks++; if (bus.node_in_stb !== 3'b000) begin failures++; $display("FAIL reset_stb got=%b exp=000", bus.node_in_stb); end
        checks++; if (bus.link_ok !== 3'b000) begin failures++; $display("FAIL reset_link_ok got=%b exp=000", bus.link_ok); end
        checks++; if (bus.par_err !== 3'b000) begin failures++; $display("FAIL reset_par_err got=%b exp=000", bus.par_err); end
        checks++; if (flushing !== 1'b0) begin failures++; $display("FAIL reset_flushing got=%b exp=0", flushing); end
        rst_n = 1'b1;
    endtask
    task automatic test_watchdog_idle();
        for (int k = 0; k < 260; k++) begin
            tick();
            checks++; if (bus.link_ok !== 3'b000) begin failures++; $display("FAIL idle_link_ok cyc=%0d got=%b exp=000", k, bus.link_ok); end
        end
    endtask
    task automatic test_forward();
        bus.node_out[1]     = 32'hDEADBEEF;
        bus.node_out_stb[1] = 1'b1;
        for (int k = 1; k <= HL; k++) begin
            tick();
            idle_inputs();
            if (k < HL) begin
                checks++; if (bus.node_in_stb !== 3'b000) begin failures++; $display("FAIL fwd_early k=%0d got=%b exp=000", k, bus.node_in_stb); end
            end
        end
        checks++; if (bus.node_in_stb !== 3'b001) begin failures++; $display("FAIL fwd_stb got=%b exp=001", bus.node_in_stb); end
        checks++; if (bus.node_in[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL fwd_data0 got=%h exp=deadbeef", bus.node_in[0]); end
        checks++; if (bus.node_in[1] !== 32'h0 || bus.node_in[2] !== 32'h0) begin failures++; $display("FAIL fwd_others got=%h/%h exp=0/0", bus.node_in[1], bus.node_in[2]); end
        tick();
        checks++; if (bus.node_in_stb !== 3'b000) begin failures++; $display("FAIL fwd_stb_once got=%b exp=000", bus.node_in_stb); end
        checks++; if (bus.node_in[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL fwd_hold got=%h exp=deadbeef", bus.node_in[0]); end
        checks++; if (bus.link_ok !== 3'b001) begin failures++; $display("FAIL fwd_link_ok got=%b exp=001", bus.link_ok); end
    endtask
    task automatic test_stale();
        repeat (SM - 1) tick();
        checks++; if (bus.link_ok !== 3'b001) begin failures++; $display("FAIL stale_before got=%b exp=001", bus.link_ok); end
        tick();
        checks++; if (bus.link_ok !== 3'b000) begin failures++; $display("FAIL stale_after got=%b exp=000", bus.link_ok); end
    endtask
    task automatic test_back_to_back_bcast();
        change_mode(MODE_BCAST);
        for (int k = 0; k <= 8; k++) begin
            bus.node_out[0]     = (k < 5) ? DW'(k + 1) : '0;
            bus.node_out_stb[0] = (k < 5);
            tick();
            if (k >= 3 && k <= 7) begin
                checks++; if (bus.node_in_stb !== 3'b110) begin failures++; $display("FAIL bcast_stb k=%0d got=%b exp=110", k, bus.node_in_stb); end
                checks++; if (bus.node_in[1] !== DW'(k - 2) || bus.node_in[2] !== DW'(k - 2)) begin failures++; $display("FAIL bcast_data k=%0d got=%h/%h exp=%0d", k, bus.node_in[1], bus.node_in[2], k - 2); end
            end else begin
                checks++; if (bus.node_in_stb !== 3'b000) begin failures++; $display("FAIL bcast_idle k=%0d got=%b exp=000", k, bus.node_in_stb); end
            end
        end
        idle_inputs();
    endtask
    task automatic test_flush();
        change_mode(MODE_FWD);
        bus.node_out[1]     = 32'h0000_00A1;
        bus.node_out_stb[1] = 1'b1;
        tick();
        idle_inputs();
        bus.node_out[2]     = 32'h0000_00B2;
        bus.node_out_stb[2] = 1'b1;
        tick();
        idle_inputs();
        mode = MODE_REV;
        checks++; if (flushing !== 1'b0) begin failures++; $display("FAIL flush_pre got=%b exp=0", flushing); end
        tick();
        for (int k = 0; k < HL; k++) begin
            checks++; if (flushing !== 1'b1) begin failures++; $display("FAIL flush_on k=%0d got=%b exp=1", k, flushing); end
            checks++; if (bus.node_in_stb !== 3'b000) begin failures++; $display("FAIL flush_stb k=%0d got=%b exp=000", k, bus.node_in_stb); end
            if (k == 0) begin
                bus.node_out[0]     = 32'h77;
                bus.node_out_stb[0] = 1'b1;
            end else begin
                idle_inputs();
            end
            tick();
        end
        idle_inputs();
        checks++; if (flushing !== 1'b0) begin failures++; $display("FAIL flush_off got=%b exp=0", flushing); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.node_in_stb !== 3'b000) begin failures++; $display("FAIL flush_dropped k=%0d got=%b exp=000", k, bus.node_in_stb); end
            tick();
        end
        checks++; if (bus.node_in[0] !== 32'hDEADBEEF || bus.node_in[1] !== 32'd5 || bus.node_in[2] !== 32'd5) begin failures++; $display("FAIL flush_hold got=%h exp=00000005_00000005_deadbeef", bus.node_in); end
        bus.node_out[0]     = 32'h1234;
        bus.node_out[2]     = 32'h5678;
        bus.node_out_stb    = 3'b101;
        tick();
        idle_inputs();
        repeat (HL - 1) tick();
        checks++; if (bus.node_in_stb !== 3'b011) begin failures++; $display("FAIL rev_stb got=%b exp=011", bus.node_in_stb); end
        checks++; if (bus.node_in[1] !== 32'h1234 || bus.node_in[0] !== 32'h5678 || bus.node_in[2] !== 32'd5) begin failures++; $display("FAIL rev_data got=%h exp=00000005_00001234_00005678", bus.node_in); end
    endtask
    task automatic test_loopback();
        change_mode(MODE_LOOP);
        bus.node_out[0]  = 32'h111;
        bus.node_out[1]  = 32'h222;
        bus.node_out[2]  = 32'h333;
        bus.node_out_stb = 3'b111;
        tick();
        idle_inputs();
        repeat (HL - 1) tick();
        checks++; if (bus.node_in_stb !== 3'b111) begin failures++; $display("FAIL loop_stb got=%b exp=111", bus.node_in_stb); end
        checks++; if (bus.node_in[0] !== 32'h111 || bus.node_in[1] !== 32'h222 || bus.node_in[2] !== 32'h333) begin failures++; $display("FAIL loop_data got=%h exp=00000333_00000222_00000111", bus.node_in); end
    endtask
    task automatic test_parity();
        change_mode(MODE_FWD);
        bus.node_out[2]     = 32'hAA55;
        bus.node_out_stb[2] = 1'b1;
        bus.par_inj[2]      = 1'b1;
        tick();
        idle_inputs();
        repeat (HL - 1) tick();
`ifdef CLUSTER_RING_PARITY_EN
        checks++; if (bus.node_in_stb !== 3'b000) begin failures++; $display("FAIL par_stb got=%b exp=000", bus.node_in_stb); end
        checks++; if (bus.node_in[1] !== 32'h222) begin failures++; $display("FAIL par_hold got=%h exp=222", bus.node_in[1]); end
        tick();
        checks++; if (bus.par_err !== 3'b010) begin failures++; $display("FAIL par_err_set got=%b exp=010", bus.par_err); end
        par_clr = 1'b1;
        tick();
        par_clr = 1'b0;
        checks++; if (bus.par_err !== 3'b000) begin failures++; $display("FAIL par_err_clr got=%b exp=000", bus.par_err); end
        bus.node_out[2]     = 32'hAA55;
        bus.node_out_stb[2] = 1'b1;
        bus.par_inj[2]      = 1'b1;
        tick();
        idle_inputs();
        repeat (HL - 1) tick();
        par_clr = 1'b1;
        tick();
        par_clr = 1'b0;
        checks++; if (bus.par_err !== 3'b010) begin failures++; $display("FAIL par_err_wins got=%b exp=010", bus.par_err); end
`else
        checks++; if (bus.node_in_stb !== 3'b010) begin failures++; $display("FAIL nopar_stb got=%b exp=010", bus.node_in_stb); end
        checks++; if (bus.node_in[1] !== 32'hAA55) begin failures++; $display("FAIL nopar_data got=%h exp=aa55", bus.node_in[1]); end
        par_clr = 1'b1;
        tick();
        par_clr = 1'b0;
        checks++; if (bus.par_err !== 3'b000) begin failures++; $display("FAIL nopar_err got=%b exp=000", bus.par_err); end
`endif
    endtask
    task automatic test_reset_mid();
        bus.node_out[1]     = 32'hCAFE;
        bus.node_out_stb[1] = 1'b1;
        tick();
        idle_inputs();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.node_in !== '0) begin failures++; $display("FAIL rstmid_node_in got=%h exp=0", bus.node_in); end
        checks++; if (bus.link_ok !== 3'b000) begin failures++; $display("FAIL rstmid_link_ok got=%b exp=000", bus.link_ok); end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (bus.node_in_stb !== 3'b000 || bus.node_in !== '0) begin failures++; $display("FAIL rstmid_drop k=%0d got=%b/%h exp=000/0", k, bus.node_in_stb, bus.node_in); end
        end
        rst_n = 1'b0;
        tick();
        rst_n               = 1'b1;
        bus.node_out[1]     = 32'hF00D;
        bus.node_out_stb[1] = 1'b1;
        tick();
        idle_inputs();
        repeat (HL - 1) tick();
        checks++; if (bus.node_in_stb !== 3'b001 || bus.node_in[0] !== 32'hF00D) begin failures++; $display("FAIL rst_first_stb got=%b/%h exp=001/f00d", bus.node_in_stb, bus.node_in[0]); end
    endtask
    initial begin
        test_reset();
        test_watchdog_idle();
        test_forward();
        test_stale();
        test_back_to_back_bcast();
        test_flush();
        test_loopback();
        test_parity();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
